pulse_freq_meter: RTL and testbench

Receive-side counterpart of the waveform generator: it takes a pulse train (e.g. the generator's Pulse output looped back, or an external source) and measures it. Per rising edge it reports period and high time in sysclk cycles, plus lock and loss-of-signal status. It sits beside the generator so the frequency selected by Scale can be checked on hardware and in simulation.

---
 rtl/pulse_freq_meter_pkg.sv | 18 +
 rtl/pulse_freq_meter_edge_sync.sv | 31 +++
 rtl/pulse_freq_meter.sv | 150 +++++++++++++++
 tb/tb_pulse_freq_meter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_freq_meter_pkg.sv
// rtl/pulse_freq_meter_pkg.sv - shared state encoding and default sizes for the pulse frequency meter
package pulse_freq_meter_pkg;

  // Default counter width; period/high-time outputs share it
  localparam int DEFAULT_CNT_W   = 24;
  // Default number of sysclk cycles without a rising edge before loss of signal
  localparam int DEFAULT_TIMEOUT = 10_000_000;
  // Default lock tolerance between consecutive period measurements
  localparam int DEFAULT_TOL     = 1;

  // WAIT_EDGE: no rise since reset. MEASURE: have a reference rise. LOST: timed out.
  typedef enum logic [1:0] {
    ST_WAIT_EDGE = 2'd0,
    ST_MEASURE   = 2'd1,
    ST_LOST      = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_freq_meter_edge_sync.sv
// rtl/pulse_freq_meter_edge_sync.sv - two-flop synchronizer with rising-edge detect
module pulse_freq_meter_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic s_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Bring the asynchronous pin into the clock domain and keep one cycle of history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Flops reset low, so a pin already high at reset release yields one rise
  assign s_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/pulse_freq_meter.sv
// rtl/pulse_freq_meter.sv - measures period and high time of a pulse train with lock and loss-of-signal status
module pulse_freq_meter
  import pulse_freq_meter_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TOL     = DEFAULT_TOL
) (
  input  logic             sysclk_i,
  input  logic             reset_ni,
  input  logic             pulse_in_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic             meas_valid_o,
  output logic             locked_o,
  output logic             no_signal_o
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   TOL_W        = (CNT_W + 1)'(TOL);

  logic s;
  logic rise;

  state_e           state_q,       state_d;
  logic [CNT_W-1:0] period_cnt_q,  period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q,    high_cnt_d;
  logic [CNT_W-1:0] period_q,      period_d;
  logic [CNT_W-1:0] high_time_q,   high_time_d;
  logic [CNT_W-1:0] prev_period_q, prev_period_d;
  logic             meas_valid_q,  meas_valid_d;
  logic             locked_q,      locked_d;

  logic [CNT_W-1:0] new_period;
  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   abs_diff;
  logic             timeout_hit;
  logic             within_tol;

  pulse_freq_meter_edge_sync u_edge_sync (
    .clk_i  (sysclk_i),
    .rst_ni (reset_ni),
    .d_i    (pulse_in_i),
    .s_o    (s),
    .rise_o (rise)
  );

  // The counter holds cycles since the last rise minus one, so the period includes the rise cycle
  assign new_period  = period_cnt_q + CNT_W'(1);
  // One extra bit so a shorter new period gives a negative difference instead of wrapping
  assign diff        = {1'b0, new_period} - {1'b0, prev_period_q};
  assign abs_diff    = diff[CNT_W] ? (~diff + (CNT_W + 1)'(1)) : diff;
  assign within_tol  = (prev_period_q != '0) && (abs_diff <= TOL_W);
  // A rise on the threshold cycle is a valid measurement, so it beats the timeout
  assign timeout_hit = (period_cnt_q == TIMEOUT_LAST) && !rise;

  // Next-state for the FSM, measurement counters and result registers
  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    high_time_d   = high_time_q;
    prev_period_d = prev_period_q;
    meas_valid_d  = 1'b0;
    locked_d      = locked_q;

    if (rise) begin
      period_cnt_d = '0;
    end else if (period_cnt_q == CNT_MAX) begin
      period_cnt_d = period_cnt_q;
    end else begin
      period_cnt_d = period_cnt_q + CNT_W'(1);
    end

    if (rise) begin
      high_cnt_d = CNT_W'(1);
    end else if (s && (high_cnt_q != CNT_MAX)) begin
      high_cnt_d = high_cnt_q + CNT_W'(1);
    end else begin
      high_cnt_d = high_cnt_q;
    end

    unique case (state_q)
      ST_WAIT_EDGE: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end else if (timeout_hit) begin
          state_d = ST_LOST;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          period_d      = new_period;
          high_time_d   = high_cnt_q;
          meas_valid_d  = 1'b1;
          locked_d      = within_tol;
          prev_period_d = new_period;
        end else if (timeout_hit) begin
          state_d = ST_LOST;
        end
      end
      ST_LOST: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end
      end
      default: begin
        state_d = ST_WAIT_EDGE;
      end
    endcase

    // Losing the signal discards results and the lock reference together
    if (state_d == ST_LOST) begin
      period_d      = '0;
      high_time_d   = '0;
      prev_period_d = '0;
      locked_d      = 1'b0;
    end
  end

  // State, counters and results register together on every sysclk edge
  always_ff @(posedge sysclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= ST_WAIT_EDGE;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      period_q      <= '0;
      high_time_q   <= '0;
      prev_period_q <= '0;
      meas_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      period_q      <= period_d;
      high_time_q   <= high_time_d;
      prev_period_q <= prev_period_d;
      meas_valid_q  <= meas_valid_d;
      locked_q      <= locked_d;
    end
  end

  assign period_o     = period_q;
  assign high_time_o  = high_time_q;
  assign meas_valid_o = meas_valid_q;
  assign locked_o     = locked_q;
  assign no_signal_o  = (state_q == ST_LOST);

endmodule

// File: tb/tb_pulse_freq_meter.sv
// tb/tb_pulse_freq_meter.sv - randomized and directed bench for pulse_freq_meter against a gap-level model
module tb_pulse_freq_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;
  localparam int TOL     = 1;

  logic             sysclk_i   = 1'b0;
  logic             reset_ni   = 1'b0;
  logic             pulse_in_i = 1'b0;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_time_o;
  logic             meas_valid_o;
  logic             locked_o;
  logic             no_signal_o;

  int errors = 0;
  int checks = 0;

  pulse_freq_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(TOL)) dut (
    .sysclk_i     (sysclk_i),
    .reset_ni     (reset_ni),
    .pulse_in_i   (pulse_in_i),
    .period_o     (period_o),
    .high_time_o  (high_time_o),
    .meas_valid_o (meas_valid_o),
    .locked_o     (locked_o),
    .no_signal_o  (no_signal_o)
  );

  always #5 sysclk_i = ~sysclk_i;

  // Model: pin samples per edge; a rise is registered two edges after the pin is first seen high.
  // A measurement is the gap between two registered rises with no timeout in between.
  bit hist[$];
  int n = 0, anchor = 0, last_rise = 0, prev_meas = 0;
  bit have_anchor = 0, lost = 0;
  int m_period = 0, m_high = 0;
  bit m_mv = 0, m_locked = 0, m_ns = 0;
  int gap, highs, d;

  function automatic bit pin_at(int k);
    if (k < 1 || k > hist.size()) return 1'b0;
    return hist[k-1];
  endfunction

  always @(posedge sysclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hist.delete();
      n = 0; anchor = 0; last_rise = 0; prev_meas = 0;
      have_anchor = 0; lost = 0;
      m_period = 0; m_high = 0; m_mv = 0; m_locked = 0; m_ns = 0;
    end else begin
      n = n + 1;
      hist.push_back(pulse_in_i);
      m_mv = 0;
      if (pin_at(n-2) && !pin_at(n-3)) begin
        if (have_anchor) begin
          gap = n - last_rise;
          highs = 0;
          for (int k = last_rise - 2; k <= n - 3; k++) highs += int'(pin_at(k));
          d = gap - prev_meas;
          if (d < 0) d = -d;
          m_period = gap;
          m_high = highs;
          m_mv = 1;
          m_locked = (prev_meas != 0) && (d <= TOL);
          prev_meas = gap;
        end
        have_anchor = 1; last_rise = n; anchor = n; lost = 0;
      end else if (!lost && (n - anchor == TIMEOUT)) begin
        lost = 1; have_anchor = 0; prev_meas = 0;
        m_period = 0; m_high = 0; m_locked = 0;
      end
      m_ns = lost;
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge
  always @(negedge sysclk_i) begin
    checks++;
    if (period_o !== CNT_W'(m_period) || high_time_o !== CNT_W'(m_high) ||
        meas_valid_o !== m_mv || locked_o !== m_locked || no_signal_o !== m_ns) begin
      errors++;
      $display("FAIL cycle_compare t=%0t: dut period=%0d high=%0d mv=%0b lock=%0b nosig=%0b; model period=%0d high=%0d mv=%0b lock=%0b nosig=%0b",
               $time, period_o, high_time_o, meas_valid_o, locked_o, no_signal_o,
               m_period, m_high, m_mv, m_locked, m_ns);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input bit v, input int c);
    for (int i = 0; i < c; i++) begin
      @(negedge sysclk_i);
      pulse_in_i = v;
    end
  endtask

  task automatic drive_pulse(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic do_reset();
    @(negedge sysclk_i);
    #3 reset_ni = 1'b0;
    repeat (2) @(negedge sysclk_i);
    #3 reset_ni = 1'b1;
  endtask

  task automatic wait_mv(input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge sysclk_i);
      cyc++;
    end while (!meas_valid_o && cyc < bound);
    if (!meas_valid_o) begin
      checks++;
      errors++;
      $display("FAIL wait_mv: no strobe within %0d cycles", bound);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, per, hi, cnt, kind;

    repeat (3) @(negedge sysclk_i);
    check("reset_period", int'(period_o), 0);
    check("reset_valid", int'(meas_valid_o), 0);
    check("reset_nosig", int'(no_signal_o), 0);
    #3 reset_ni = 1'b1;

    // Clean train period 10 high 3
    fork
      repeat (4) drive_pulse(3, 7);
      begin
        wait_mv(200, cyc);
        check("t1_first_latency", cyc, 14);
        check("t1_period", int'(period_o), 10);
        check("t1_high", int'(high_time_o), 3);
        check("t1_unlocked", int'(locked_o), 0);
        wait_mv(200, cyc);
        check("t1_spacing", cyc, 10);
        check("t1_locked", int'(locked_o), 1);
      end
    join

    // Period steps 10 -> 14 -> 10 -> 11
    fork
      begin
        repeat (3) drive_pulse(3, 11);
        repeat (2) drive_pulse(3, 7);
        repeat (2) drive_pulse(3, 8);
      end
      begin
        wait_mv(200, cyc);
        wait_mv(200, cyc);
        check("t2_p14", int'(period_o), 14);
        check("t2_p14_unlocked", int'(locked_o), 0);
        wait_mv(200, cyc);
        check("t2_p14_locked", int'(locked_o), 1);
        wait_mv(200, cyc);
        wait_mv(200, cyc);
        check("t2_back10_unlocked", int'(locked_o), 0);
        wait_mv(200, cyc);
        wait_mv(200, cyc);
        check("t2_p11", int'(period_o), 11);
        check("t2_p11_locked", int'(locked_o), 1);
      end
    join

    // Input stops low after a rise
    fork
      begin
        drive_pulse(3, 7);
        hold(1'b1, 3);
        hold(1'b0, 120);
      end
      begin
        wait_mv(200, cyc);
        wait_mv(200, cyc);
        check("t3_last_period", int'(period_o), 10);
        for (int i = 1; i <= TIMEOUT; i++) begin
          @(negedge sysclk_i);
          if (i == TIMEOUT - 1) check("t3_nosig_before", int'(no_signal_o), 0);
          if (i == TIMEOUT) begin
            check("t3_nosig_at", int'(no_signal_o), 1);
            check("t3_period_cleared", int'(period_o), 0);
            check("t3_lock_cleared", int'(locked_o), 0);
          end
        end
      end
    join
    fork
      repeat (3) drive_pulse(4, 8);
      begin
        wait_mv(200, cyc);
        check("t3_recover_period", int'(period_o), 12);
        check("t3_recover_nosig", int'(no_signal_o), 0);
      end
    join

    // Pin high through reset release
    hold(1'b1, 1);
    do_reset();
    hold(1'b1, 150);
    check("t4_lost", int'(no_signal_o), 1);
    check("t4_period", int'(period_o), 0);

    // Reset mid-period while locked
    hold(1'b0, 5);
    repeat (5) drive_pulse(3, 7);
    check("t5_locked_before", int'(locked_o), 1);
    hold(1'b1, 2);
    #3 reset_ni = 1'b0;
    #1;
    check("t5_async_period", int'(period_o), 0);
    check("t5_async_high", int'(high_time_o), 0);
    check("t5_async_locked", int'(locked_o), 0);
    hold(1'b0, 2);
    #3 reset_ni = 1'b1;
    fork
      repeat (4) drive_pulse(3, 7);
      begin
        wait_mv(200, cyc);
        check("t5_second_rise_latency", cyc, 14);
        check("t5_period", int'(period_o), 10);
      end
    join

    // Rise on the timeout threshold cycle
    do_reset();
    fork
      repeat (3) drive_pulse(5, 95);
      begin
        wait_mv(400, cyc);
        check("t6_period", int'(period_o), 100);
        check("t6_high", int'(high_time_o), 5);
        check("t6_nosig", int'(no_signal_o), 0);
        wait_mv(400, cyc);
        check("t6_locked", int'(locked_o), 1);
      end
    join

    // Randomized segments, checked by the every-cycle compare
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) hold(1'b0, $urandom_range(90, 130));
      else if (kind == 1) hold(1'b1, $urandom_range(90, 130));
      else if (kind == 2) do_reset();
      else begin
        per = $urandom_range(2, 25);
        hi = $urandom_range(1, per - 1);
        cnt = $urandom_range(2, 6);
        for (int p = 0; p < cnt; p++) drive_pulse(hi, per - hi + $urandom_range(0, 1));
      end
    end
    hold(1'b0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
